// File: rtl/hazard_ctrl.sv
// Fetch/decode/execute sequencing, operand forwarding and debug halt/step drain control.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
    parameter int DRAIN_DEPTH = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_de,
    input  logic [4:0]       rs2_de,
    input  logic [4:0]       rs1_ex,
    input  logic [4:0]       rs2_ex,
    input  logic [4:0]       rd_ex,
    input  logic [4:0]       rd_me,
    input  logic [4:0]       rd_wb,
    input  logic             RUWr_ex,
    input  logic             RUWr_me,
    input  logic             RUWr_wb,
    input  logic [1:0]       RUDataWrSrc_ex,
    input  logic             NextPcSrc,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic             resume_req,
    output logic             pc_en,
    output logic             de_en,
    output logic             de_flush,
    output logic             ex_flush,
    output logic [1:0]       fwdA_sel,
    output logic [1:0]       fwdB_sel,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;
    localparam logic [1:0] S_STEP   = 2'd3;

    localparam logic [2:0] DCNT_INIT = 3'(DRAIN_DEPTH);

    logic [1:0] state, state_nxt;
    logic [2:0] dcnt, dcnt_nxt;
    logic       lu;

    // Memory stage holds the newest value, so it wins over writeback.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] rdm, input logic wrm,
                                           input logic [4:0] rdw, input logic wrw);
        if (wrm && (rdm != 5'd0) && (rdm == rs))
            return 2'b01;
        else if (wrw && (rdw != 5'd0) && (rdw == rs))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign lu = RUWr_ex && (RUDataWrSrc_ex == 2'b01) && (rd_ex != 5'd0) &&
                ((rd_ex == rs1_de) || (rd_ex == rs2_de));

    always_comb begin
        pc_en    = 1'b1;
        de_en    = 1'b1;
        de_flush = 1'b0;
        ex_flush = 1'b0;
        halted   = 1'b0;
        fwdA_sel = fwd_sel(rs1_ex, rd_me, RUWr_me, rd_wb, RUWr_wb);
        fwdB_sel = fwd_sel(rs2_ex, rd_me, RUWr_me, rd_wb, RUWr_wb);

        case (state)
            S_DRAIN: begin
                pc_en    = 1'b0;
                de_flush = 1'b1;
            end
            S_HALTED: begin
                pc_en    = 1'b0;
                de_flush = 1'b1;
                halted   = 1'b1;
            end
            default: ;
        endcase

        if (lu) begin
            pc_en    = 1'b0;
            de_en    = 1'b0;
            de_flush = 1'b0;
            ex_flush = 1'b1;
        end

        // A taken branch redirects the PC even while draining or halted; the new PC is the resume point.
        if (NextPcSrc) begin
            pc_en    = 1'b1;
            de_en    = 1'b1;
            de_flush = 1'b1;
            ex_flush = 1'b1;
        end

        if (!rst_n) begin
            pc_en    = 1'b0;
            de_en    = 1'b0;
            de_flush = 1'b1;
            ex_flush = 1'b1;
            halted   = 1'b0;
            fwdA_sel = 2'b00;
            fwdB_sel = 2'b00;
        end
    end

    always_comb begin
        state_nxt = state;
        dcnt_nxt  = dcnt;
        case (state)
            S_RUN: begin
                if (halt_req) begin
                    state_nxt = S_DRAIN;
                    dcnt_nxt  = DCNT_INIT;
                end
            end
            S_DRAIN: begin
                if (!lu) begin
                    dcnt_nxt = dcnt - 3'd1;
                    if (dcnt == 3'd1)
                        state_nxt = S_HALTED;
                end
            end
            S_HALTED: begin
                if (resume_req)
                    state_nxt = S_RUN;
                else if (step_req)
                    state_nxt = S_STEP;
            end
            default: begin
                // STEP lets exactly one instruction into decode, held back while lu stalls it.
                if (!lu) begin
                    state_nxt = S_DRAIN;
                    dcnt_nxt  = DCNT_INIT;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RUN;
            dcnt  <= 3'd0;
        end else begin
            state <= state_nxt;
            dcnt  <= dcnt_nxt;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (lu && !NextPcSrc)
                stall_cnt <= stall_cnt + 1'b1;
            if (NextPcSrc)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: combinational vector table plus drain/halt/step/reset sequences.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1_de, rs2_de, rs1_ex, rs2_ex, rd_ex, rd_me, rd_wb;
    logic        RUWr_ex, RUWr_me, RUWr_wb;
    logic [1:0]  RUDataWrSrc_ex;
    logic        NextPcSrc, halt_req, step_req, resume_req;
    logic        pc_en, de_en, de_flush, ex_flush, halted;
    logic [1:0]  fwdA_sel, fwdB_sel;
    logic [31:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    hazard_ctrl #(.DRAIN_DEPTH(4), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_de(rs1_de), .rs2_de(rs2_de), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
        .rd_ex(rd_ex), .rd_me(rd_me), .rd_wb(rd_wb),
        .RUWr_ex(RUWr_ex), .RUWr_me(RUWr_me), .RUWr_wb(RUWr_wb),
        .RUDataWrSrc_ex(RUDataWrSrc_ex), .NextPcSrc(NextPcSrc),
        .halt_req(halt_req), .step_req(step_req), .resume_req(resume_req),
        .pc_en(pc_en), .de_en(de_en), .de_flush(de_flush), .ex_flush(ex_flush),
        .fwdA_sel(fwdA_sel), .fwdB_sel(fwdB_sel), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rs1_de, rs2_de, rs1_ex, rs2_ex, rd_ex, rd_me, rd_wb;
        logic       wr_ex, wr_me, wr_wb;
        logic [1:0] src_ex;
        logic       npc;
        logic [7:0] exp;   // {pc_en, de_en, de_flush, ex_flush, fwdA, fwdB}
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] outs();
        return {pc_en, de_en, de_flush, ex_flush, fwdA_sel, fwdB_sel};
    endfunction

    task automatic clear_inputs();
        rs1_de = 0; rs2_de = 0; rs1_ex = 0; rs2_ex = 0;
        rd_ex = 0; rd_me = 0; rd_wb = 0;
        RUWr_ex = 0; RUWr_me = 0; RUWr_wb = 0; RUDataWrSrc_ex = 2'b00;
        NextPcSrc = 0; halt_req = 0; step_req = 0; resume_req = 0;
    endtask

    // One rising edge, then return just after the falling edge for driving and sampling.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        //                 rs1d rs2d rs1e rs2e rde  rdm  rdw  we me wb src   npc  exp
        vecs[0]  = '{5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 8'b0001_0000};
        vecs[1]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 8'b1100_0000};
        vecs[2]  = '{5'd3, 5'd9, 5'd0, 5'd0, 5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 8'b0001_0000};
        vecs[3]  = '{5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'b1100_0000};
        vecs[4]  = '{5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 8'b1100_0000};
        vecs[5]  = '{5'd0, 5'd0, 5'd7, 5'd7, 5'd0, 5'd7, 5'd7, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 8'b1100_0101};
        vecs[6]  = '{5'd0, 5'd0, 5'd7, 5'd7, 5'd0, 5'd7, 5'd7, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 8'b1100_1010};
        vecs[7]  = '{5'd0, 5'd0, 5'd7, 5'd3, 5'd0, 5'd7, 5'd3, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 8'b1100_0110};
        vecs[8]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 8'b1100_0000};
        vecs[9]  = '{5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 8'b1111_0000};
        vecs[10] = '{5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 5'd4, 5'd0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 8'b1111_0100};

        clear_inputs();
        rst_n = 1'b0;
        rs1_ex = 5'd7; rd_me = 5'd7; RUWr_me = 1'b1;
        #1;
        check("reset_outs", {24'd0, outs()}, {24'd0, 8'b0011_0000});
        check("reset_halted", {31'd0, halted}, 32'd0);
        check("reset_stall_cnt", stall_cnt, 32'd0);
        check("reset_flush_cnt", flush_cnt, 32'd0);
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Vector table, one clock per vector, all in RUN.
        for (int i = 0; i < 11; i++) begin
            rs1_de = vecs[i].rs1_de; rs2_de = vecs[i].rs2_de;
            rs1_ex = vecs[i].rs1_ex; rs2_ex = vecs[i].rs2_ex;
            rd_ex = vecs[i].rd_ex; rd_me = vecs[i].rd_me; rd_wb = vecs[i].rd_wb;
            RUWr_ex = vecs[i].wr_ex; RUWr_me = vecs[i].wr_me; RUWr_wb = vecs[i].wr_wb;
            RUDataWrSrc_ex = vecs[i].src_ex; NextPcSrc = vecs[i].npc;
            #1;
            check($sformatf("vec%0d", i), {24'd0, outs()}, {24'd0, vecs[i].exp});
            check($sformatf("vec%0d_halted", i), {31'd0, halted}, 32'd0);
            if (vecs[i].npc) exp_flush++;
            else if (!vecs[i].exp[7]) exp_stall++;
            tick();
        end
        clear_inputs();
        #1;
`ifdef HAZARD_PERF_CNT_EN
        check("stall_cnt", stall_cnt, 32'(exp_stall));
        check("flush_cnt", flush_cnt, 32'(exp_flush));
`else
        check("stall_cnt_off", stall_cnt, 32'd0);
        check("flush_cnt_off", flush_cnt, 32'd0);
`endif

        // Load-use: one bubble, then the dependent instruction forwards from writeback.
        rd_ex = 5'd5; RUWr_ex = 1'b1; RUDataWrSrc_ex = 2'b01; rs1_de = 5'd5;
        #1;
        check("lu_stall", {24'd0, outs()}, {24'd0, 8'b0001_0000});
        tick();
        clear_inputs();
        rs1_ex = 5'd5; rd_wb = 5'd5; RUWr_wb = 1'b1;
        #1;
        check("lu_after", {24'd0, outs()}, {24'd0, 8'b1100_1000});
        clear_inputs();

        // Halt: pc_en drops on the next cycle, halted exactly 4 cycles after that.
        halt_req = 1'b1;
        #1;
        check("halt_req_cycle_pc_en", {31'd0, pc_en}, 32'd1);
        tick();
        halt_req = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            #1;
            check($sformatf("drain%0d_halted", k), {31'd0, halted}, (k >= 4) ? 32'd1 : 32'd0);
            check($sformatf("drain%0d_pc_en", k), {31'd0, pc_en}, 32'd0);
            check($sformatf("drain%0d_de_flush", k), {31'd0, de_flush}, 32'd1);
            if (k < 4) tick();
        end
        check("halted_ex_flush", {31'd0, ex_flush}, 32'd0);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        #1;
        check("halt_ignored_in_halted", {31'd0, halted}, 32'd1);
        resume_req = 1'b1;
        tick();
        resume_req = 1'b0;
        #1;
        check("resume_outs", {27'd0, halted, outs()[7:4]}, {27'd0, 5'b0_1100});

        // Halt again, then single step.
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        repeat (4) tick();
        #1;
        check("rehalted", {31'd0, halted}, 32'd1);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        #1;
        check("step_cycle", {27'd0, halted, outs()[7:4]}, {27'd0, 5'b0_1100});
        tick();
        for (int k = 0; k <= 4; k++) begin
            #1;
            check($sformatf("step_drain%0d", k), {30'd0, halted, de_flush},
                  (k >= 4) ? 32'd3 : 32'd1);
            if (k < 4) tick();
        end
        step_req = 1'b1; resume_req = 1'b1;
        tick();
        step_req = 1'b0; resume_req = 1'b0;
        #1;
        check("step_and_resume", {27'd0, halted, outs()[7:4]}, {27'd0, 5'b0_1100});
        tick();
        #1;
        check("resume_stays_run", {31'd0, pc_en}, 32'd1);

        // A load-use cycle during DRAIN holds the count one extra cycle.
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        tick();
        rd_ex = 5'd6; RUWr_ex = 1'b1; RUDataWrSrc_ex = 2'b01; rs2_de = 5'd6;
        tick();
        clear_inputs();
        for (int k = 2; k <= 5; k++) begin
            #1;
            check($sformatf("lu_drain%0d_halted", k), {31'd0, halted}, (k >= 5) ? 32'd1 : 32'd0);
            if (k < 5) tick();
        end
        resume_req = 1'b1;
        tick();
        resume_req = 1'b0;

        // Branch during DRAIN redirects fetch.
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        NextPcSrc = 1'b1;
        #1;
        check("drain_branch", {28'd0, outs()[7:4]}, {28'd0, 4'b1111});
        NextPcSrc = 1'b0;
        tick();

        // Asynchronous reset mid-DRAIN.
        #2;
        rs1_ex = 5'd7; rd_me = 5'd7; RUWr_me = 1'b1;
        rst_n = 1'b0;
        #1;
        check("midrst_outs", {24'd0, outs()}, {24'd0, 8'b0011_0000});
        check("midrst_stall_cnt", stall_cnt, 32'd0);
        check("midrst_flush_cnt", flush_cnt, 32'd0);
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("postrst_run", {27'd0, halted, outs()[7:4]}, {27'd0, 5'b0_1100});
        repeat (6) tick();
        #1;
        check("postrst_no_halt", {30'd0, halted, pc_en}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
